// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC generator, one-outstanding imem fetch FSM, 1-entry
// hold buffer and IF->ID register. Optional misaligned-redirect trap: IF_MISALIGN_CHK_EN.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_IF,
  input  logic        jmp_vld_IF,
  input  logic [31:0] jmp_addr_IF,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_pc,
  output logic [31:0] IF_inst,
  output logic        IF_inst_vld,
  output logic        if_misalign
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  state_t      state_r, state_s;
  logic [31:0] fetch_pc_r, fetch_pc_s;
  logic [31:0] req_pc_r, req_pc_s;
  logic        kill_r, kill_s;
  logic        pend_r, pend_s;
  logic        req_r;
  logic        buf_vld_r, buf_vld_s;
  logic [31:0] buf_pc_r, buf_pc_s;
  logic [31:0] buf_inst_r, buf_inst_s;
  logic [31:0] if_pc_r, if_pc_s;
  logic [31:0] if_inst_r, if_inst_s;
  logic        if_vld_r, if_vld_s;
  logic        misalign_r, misalign_s;
  logic [31:0] jmp_tgt_s;
  logic        rsp_s, accept_s, to_buf_s, buf_full_nxt_s;

`ifdef IF_MISALIGN_CHK_EN
  assign misalign_s = jmp_vld_IF && (jmp_addr_IF[1:0] != 2'b00);
  assign jmp_tgt_s  = misalign_s ? TRAP_VEC : {jmp_addr_IF[31:2], 2'b00};
`else
  logic unused_s;
  assign unused_s   = ^{jmp_addr_IF[1:0], TRAP_VEC};
  assign misalign_s = 1'b0;
  assign jmp_tgt_s  = {jmp_addr_IF[31:2], 2'b00};
`endif

  // A response only counts in WAIT with a request outstanding; kill or a redirect drops it.
  assign rsp_s          = (state_r == ST_WAIT) && imem_rvalid && pend_r;
  assign accept_s       = rsp_s && !kill_r && !jmp_vld_IF;
  assign to_buf_s       = accept_s && (hold_IF || buf_vld_r);
  assign buf_full_nxt_s = to_buf_s || (buf_vld_r && hold_IF);

  // Fetch FSM next-state, PC and kill tracking.
  always_comb begin
    state_s    = state_r;
    fetch_pc_s = fetch_pc_r;
    req_pc_s   = req_pc_r;
    kill_s     = kill_r;
    pend_s     = pend_r;
    case (state_r)
      ST_IDLE: begin
        state_s = ST_REQ;
        if (jmp_vld_IF) begin
          fetch_pc_s = jmp_tgt_s;
        end else begin
          fetch_pc_s = fetch_pc_r;
        end
      end
      ST_REQ: begin
        if (imem_gnt) begin
          state_s  = ST_WAIT;
          pend_s   = 1'b1;
          req_pc_s = fetch_pc_r;
          kill_s   = jmp_vld_IF;
        end else begin
          state_s = ST_REQ;
        end
        if (jmp_vld_IF) begin
          fetch_pc_s = jmp_tgt_s;
        end else begin
          fetch_pc_s = fetch_pc_r;
        end
      end
      ST_WAIT: begin
        if (jmp_vld_IF) begin
          fetch_pc_s = jmp_tgt_s;
          // Only an outstanding, not-yet-returned request needs its response killed.
          if (pend_r && !imem_rvalid) begin
            state_s = ST_WAIT;
            kill_s  = 1'b1;
          end else begin
            state_s = ST_REQ;
            kill_s  = 1'b0;
            pend_s  = 1'b0;
          end
        end else if (rsp_s || !pend_r) begin
          pend_s = 1'b0;
          kill_s = 1'b0;
          if (accept_s) begin
            fetch_pc_s = req_pc_r + 32'd4;
          end else begin
            fetch_pc_s = fetch_pc_r;
          end
          state_s = buf_full_nxt_s ? ST_WAIT : ST_REQ;
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
        kill_s  = 1'b0;
        pend_s  = 1'b0;
      end
    endcase
  end

  // IF->ID register and hold buffer.
  always_comb begin
    if_pc_s    = if_pc_r;
    if_inst_s  = if_inst_r;
    if_vld_s   = if_vld_r;
    buf_vld_s  = buf_vld_r;
    buf_pc_s   = buf_pc_r;
    buf_inst_s = buf_inst_r;
    if (jmp_vld_IF) begin
      if_vld_s  = 1'b0;
      if_inst_s = NOP_INST;
      buf_vld_s = 1'b0;
    end else if (hold_IF) begin
      if (to_buf_s) begin
        buf_vld_s  = 1'b1;
        buf_pc_s   = req_pc_r;
        buf_inst_s = imem_rdata;
      end else begin
        buf_vld_s = buf_vld_r;
      end
    end else if (buf_vld_r) begin
      if_pc_s   = buf_pc_r;
      if_inst_s = buf_inst_r;
      if_vld_s  = 1'b1;
      buf_vld_s = to_buf_s;
      if (to_buf_s) begin
        buf_pc_s   = req_pc_r;
        buf_inst_s = imem_rdata;
      end else begin
        buf_pc_s = buf_pc_r;
      end
    end else if (accept_s) begin
      if_pc_s   = req_pc_r;
      if_inst_s = imem_rdata;
      if_vld_s  = 1'b1;
    end else begin
      if_vld_s  = 1'b0;
      if_inst_s = NOP_INST;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      fetch_pc_r <= RESET_PC;
      req_pc_r   <= 32'h0000_0000;
      kill_r     <= 1'b0;
      pend_r     <= 1'b0;
      req_r      <= 1'b0;
      buf_vld_r  <= 1'b0;
      buf_pc_r   <= 32'h0000_0000;
      buf_inst_r <= NOP_INST;
      if_pc_r    <= 32'h0000_0000;
      if_inst_r  <= NOP_INST;
      if_vld_r   <= 1'b0;
      misalign_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      fetch_pc_r <= fetch_pc_s;
      req_pc_r   <= req_pc_s;
      kill_r     <= kill_s;
      pend_r     <= pend_s;
      req_r      <= (state_s == ST_REQ);
      buf_vld_r  <= buf_vld_s;
      buf_pc_r   <= buf_pc_s;
      buf_inst_r <= buf_inst_s;
      if_pc_r    <= if_pc_s;
      if_inst_r  <= if_inst_s;
      if_vld_r   <= if_vld_s;
      misalign_r <= misalign_s;
    end
  end

  assign imem_req    = req_r;
  assign imem_addr   = fetch_pc_r;
  assign IF_pc       = if_pc_r;
  assign IF_inst     = if_inst_r;
  assign IF_inst_vld = if_vld_r;
  assign if_misalign = misalign_r;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: table-driven streaming/hold vectors plus
// hand-written redirect, reset and misalignment sequences against a small imem model.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        hold_IF;
  logic        jmp_vld_IF;
  logic [31:0] jmp_addr_IF;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] IF_pc;
  logic [31:0] IF_inst;
  logic        IF_inst_vld;
  logic        if_misalign;

  int checks = 0;
  int errors = 0;

  // Memory model: response mem_lat cycles after grant, data = addr ^ A5A5_0000.
  int          mem_lat = 1;
  logic        stray_rv;
  logic        g1, g2;
  logic [31:0] a1, a2;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .hold_IF(hold_IF), .jmp_vld_IF(jmp_vld_IF),
    .jmp_addr_IF(jmp_addr_IF), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .IF_pc(IF_pc), .IF_inst(IF_inst), .IF_inst_vld(IF_inst_vld),
    .if_misalign(if_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      g1 <= 1'b0; g2 <= 1'b0; a1 <= 32'h0; a2 <= 32'h0;
    end else begin
      g1 <= imem_req && imem_gnt;
      a1 <= imem_addr;
      g2 <= g1;
      a2 <= a1;
    end
  end

  assign imem_rvalid = stray_rv | ((mem_lat == 2) ? g2 : g1);
  assign imem_rdata  = stray_rv ? 32'hDEAD_BEEF : (((mem_lat == 2) ? a2 : a1) ^ 32'hA5A5_0000);

  typedef struct {
    logic        hold;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_vld;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; hold_IF = 1'b0; jmp_vld_IF = 1'b0; jmp_addr_IF = 32'h0;
    imem_gnt = 1'b1; stray_rv = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  logic [31:0] exp_tgt;
  logic        exp_mis;

  initial begin
    // Expected per-cycle outputs; hold applies to the following edge.
    vecs[0]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
    vecs[1]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[2]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
    vecs[3]  = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h00};
    vecs[4]  = '{1'b0, 1'b0, 32'h04, 1'b0, 32'h00};
    vecs[5]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h04};
    vecs[6]  = '{1'b0, 1'b0, 32'h08, 1'b0, 32'h04};
    vecs[7]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h08};
    vecs[8]  = '{1'b1, 1'b0, 32'h0C, 1'b1, 32'h08};
    vecs[9]  = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
    vecs[10] = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
    vecs[11] = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h08};
    vecs[12] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h0C};
    vecs[13] = '{1'b0, 1'b0, 32'h10, 1'b0, 32'h0C};
    vecs[14] = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h10};

    rst = 1'b1; hold_IF = 1'b0; jmp_vld_IF = 1'b0; jmp_addr_IF = 32'h0;
    imem_gnt = 1'b1; stray_rv = 1'b0;
    @(negedge clk);
    chk("rst_pc", IF_pc, 32'h0);
    chk("rst_inst", IF_inst, 32'h0000_0013);
    chk("rst_vld", {31'b0, IF_inst_vld}, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_mis", {31'b0, if_misalign}, 32'h0);

    // Streaming fetch, then a 4-cycle hold with pc=8 in the register.
    mem_lat = 1;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("vec%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].exp_req});
      chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d_vld", i), {31'b0, IF_inst_vld}, {31'b0, vecs[i].exp_vld});
      chk($sformatf("vec%0d_pc", i), IF_pc, vecs[i].exp_pc);
      chk($sformatf("vec%0d_inst", i), IF_inst,
          vecs[i].exp_vld ? (vecs[i].exp_pc ^ 32'hA5A5_0000) : 32'h0000_0013);
      hold_IF = vecs[i].hold;
      step();
    end

    // Redirect while waiting on a slow response: the response is killed.
    mem_lat = 2;
    do_reset();
    step();
    chk("kw_req1", {31'b0, imem_req}, 32'h1);
    step();
    chk("kw_wait", {31'b0, imem_req}, 32'h0);
    jmp_vld_IF = 1'b1; jmp_addr_IF = 32'h0000_0200;
    step();
    jmp_vld_IF = 1'b0;
    chk("kw_noreq", {31'b0, imem_req}, 32'h0);
    chk("kw_vld3", {31'b0, IF_inst_vld}, 32'h0);
    step();
    chk("kw_req_tgt", {31'b0, imem_req}, 32'h1);
    chk("kw_addr_tgt", imem_addr, 32'h0000_0200);
    chk("kw_vld4", {31'b0, IF_inst_vld}, 32'h0);
    step();
    chk("kw_vld5", {31'b0, IF_inst_vld}, 32'h0);
    step();
    chk("kw_vld6", {31'b0, IF_inst_vld}, 32'h0);
    step();
    chk("kw_vld7", {31'b0, IF_inst_vld}, 32'h1);
    chk("kw_pc7", IF_pc, 32'h0000_0200);
    chk("kw_inst7", IF_inst, 32'hA5A5_0200);

    // Redirect in the same cycle as rvalid: response dropped, no kill.
    mem_lat = 1;
    do_reset();
    step();
    step();
    jmp_vld_IF = 1'b1; jmp_addr_IF = 32'h0000_0300;
    step();
    jmp_vld_IF = 1'b0;
    chk("sr_req", {31'b0, imem_req}, 32'h1);
    chk("sr_addr", imem_addr, 32'h0000_0300);
    chk("sr_vld3", {31'b0, IF_inst_vld}, 32'h0);
    step();
    chk("sr_vld4", {31'b0, IF_inst_vld}, 32'h0);
    step();
    chk("sr_vld5", {31'b0, IF_inst_vld}, 32'h1);
    chk("sr_pc5", IF_pc, 32'h0000_0300);
    chk("sr_inst5", IF_inst, 32'hA5A5_0300);

    // Misaligned redirect target.
`ifdef IF_MISALIGN_CHK_EN
    exp_tgt = 32'h0000_0100; exp_mis = 1'b1;
`else
    exp_tgt = 32'h0000_0200; exp_mis = 1'b0;
`endif
    do_reset();
    step();
    step();
    chk("ma_mis_pre", {31'b0, if_misalign}, 32'h0);
    jmp_vld_IF = 1'b1; jmp_addr_IF = 32'h0000_0202;
    step();
    jmp_vld_IF = 1'b0;
    chk("ma_mis", {31'b0, if_misalign}, {31'b0, exp_mis});
    chk("ma_addr", imem_addr, exp_tgt);
    step();
    chk("ma_mis_end", {31'b0, if_misalign}, 32'h0);
    step();
    chk("ma_pc", IF_pc, exp_tgt);
    chk("ma_vld", {31'b0, IF_inst_vld}, 32'h1);

    // PC wrap at the top of the address space.
    do_reset();
    step();
    step();
    jmp_vld_IF = 1'b1; jmp_addr_IF = 32'hFFFF_FFFC;
    step();
    jmp_vld_IF = 1'b0;
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    step();
    chk("wr_pc", IF_pc, 32'hFFFF_FFFC);
    chk("wr_next", imem_addr, 32'h0000_0000);
    chk("wr_req", {31'b0, imem_req}, 32'h1);

    // Reset with a kill pending, then stray rvalid in IDLE and REQ.
    mem_lat = 2;
    do_reset();
    step();
    step();
    jmp_vld_IF = 1'b1; jmp_addr_IF = 32'h0000_0040;
    step();
    jmp_vld_IF = 1'b0;
    rst = 1'b1;
    step();
    chk("rk_req", {31'b0, imem_req}, 32'h0);
    chk("rk_addr", imem_addr, 32'h0);
    mem_lat = 1; imem_gnt = 1'b0; stray_rv = 1'b1;
    rst = 1'b0;
    step();
    chk("rk_b_req", {31'b0, imem_req}, 32'h1);
    chk("rk_b_vld", {31'b0, IF_inst_vld}, 32'h0);
    step();
    chk("rk_c_addr", imem_addr, 32'h0);
    chk("rk_c_vld", {31'b0, IF_inst_vld}, 32'h0);
    stray_rv = 1'b0; imem_gnt = 1'b1;
    step();
    chk("rk_d_req", {31'b0, imem_req}, 32'h0);
    step();
    chk("rk_e_vld", {31'b0, IF_inst_vld}, 32'h1);
    chk("rk_e_pc", IF_pc, 32'h0);
    chk("rk_e_inst", IF_inst, 32'hA5A5_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
